// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing the single datamem controller port
// between the protocol controllers (0 = SPI, 1 = UART, 2 = I2C).
// The grant is registered and one-hot. The owner's access is muxed onto the
// memory port combinationally. A hold limit forces hand-over when others wait.
module dmem_arbiter #(
   parameter int NREQ     = 3,
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 32,
   parameter int MAX_HOLD = 16
) (
   input  logic                     clk_i,
   input  logic                     nrst_i,
   input  logic [NREQ-1:0]          req_i,
   input  logic [NREQ*ADDR_W-1:0]   addr_i,
   input  logic [NREQ*4-1:0]        wr_i,
   input  logic [NREQ*DATA_W-1:0]   wdata_i,
   output logic [NREQ-1:0]          gnt_o,
   output logic [NREQ-1:0]          rvalid_o,
   output logic [DATA_W-1:0]        rdata_o,
   output logic [ADDR_W-1:0]        mem_addr_o,
   output logic [3:0]               mem_wr_o,
   output logic [DATA_W-1:0]        mem_out_o,
   input  logic [DATA_W-1:0]        mem_in_i
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   // MAX_HOLD = 0 would give a zero-width counter; keep one bit in that case
   localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam bit HOLD_EN = (MAX_HOLD > 0);
   localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NREQ - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;

   typedef enum logic {ST_IDLE, ST_OWN} state_t;

   state_t            state_q, state_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [IDX_W-1:0]  last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [NREQ-1:0]   rvalid_q;
   logic [ADDR_W-1:0] mem_addr_q;

   logic [ADDR_W-1:0] addr_arr  [NREQ];
   logic [3:0]        wr_arr    [NREQ];
   logic [DATA_W-1:0] wdata_arr [NREQ];
   logic [NREQ-1:0]   acc;
   logic [NREQ-1:0]   rd_acc;
   logic              any_acc;

   logic [ADDR_W-1:0] mux_addr;
   logic [3:0]        mux_wr;
   logic [DATA_W-1:0] mux_wdata;

   logic [NREQ-1:0]   cand;
   logic              pick_found;
   logic [IDX_W-1:0]  pick_idx;
   logic              hold_hit;

   // Unpack per-requester buses and flag which requester accesses this cycle
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign addr_arr[gi]  = addr_i[gi*ADDR_W +: ADDR_W];
      assign wr_arr[gi]    = wr_i[gi*4 +: 4];
      assign wdata_arr[gi] = wdata_i[gi*DATA_W +: DATA_W];
      assign acc[gi]       = gnt_q[gi] & req_i[gi];
      assign rd_acc[gi]    = acc[gi] & (wr_arr[gi] == 4'h0);
   end

   assign any_acc = |acc;

   // AND-OR mux of the accessing requester onto the port (grant is one-hot)
   always_comb begin
      mux_addr  = '0;
      mux_wr    = '0;
      mux_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (acc[i]) begin
            mux_addr  = mux_addr | addr_arr[i];
            mux_wr    = mux_wr | wr_arr[i];
            mux_wdata = mux_wdata | wdata_arr[i];
         end
      end
   end

   // Address holds its last driven value when idle; writes are blocked during reset
   assign mem_addr_o = any_acc ? mux_addr : mem_addr_q;
   assign mem_wr_o   = nrst_i ? mux_wr : 4'h0;
   assign mem_out_o  = mux_wdata;
   assign rdata_o    = mem_in_i;
   assign gnt_o      = gnt_q;
   assign rvalid_o   = rvalid_q;

   // Round-robin search starting after the last owner; the current owner is
   // masked out, so the same search serves idle grant, release and revoke
   always_comb begin
      cand       = (state_q == ST_IDLE) ? req_i : (req_i & ~gnt_q);
      pick_found = 1'b0;
      pick_idx   = last_q;
      for (int k = 1; k <= NREQ; k++) begin
         if (!pick_found && cand[(int'(last_q) + k) % NREQ]) begin
            pick_found = 1'b1;
            pick_idx   = IDX_W'((int'(last_q) + k) % NREQ);
         end
      end
   end

   assign hold_hit = HOLD_EN && (cnt_q >= HOLD_LAST);

   // Next-state logic: grant, release/hand-over, hold-limit revoke
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               state_d = ST_OWN;
               gnt_d   = NREQ'(1) << pick_idx;
               last_d  = pick_idx;
               cnt_d   = '0;
            end
         end
         ST_OWN: begin
            if (!any_acc) begin
               // owner dropped req: hand over directly or go idle
               cnt_d = '0;
               if (pick_found) begin
                  gnt_d  = NREQ'(1) << pick_idx;
                  last_d = pick_idx;
               end else begin
                  state_d = ST_IDLE;
                  gnt_d   = '0;
               end
            end else if (hold_hit && pick_found) begin
               // this access is the last allowed one while someone waits
               gnt_d  = NREQ'(1) << pick_idx;
               last_d = pick_idx;
               cnt_d  = '0;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
   end

   // Arbiter state registers
   always_ff @(posedge clk_i) begin
      if (!nrst_i) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         last_q  <= LAST_RST;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   // Read-valid pulse one cycle after a read access; remembered port address
   always_ff @(posedge clk_i) begin
      if (!nrst_i) begin
         rvalid_q   <= '0;
         mem_addr_q <= '0;
      end else begin
         rvalid_q   <= rd_acc;
         mem_addr_q <= mem_addr_o;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (hold limit 16 and 1) share random
// stimulus; each is compared every cycle against a transaction-level model.
module tb_dmem_arbiter;

   localparam int NREQ   = 3;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;
   localparam int NDUT   = 2;
   localparam int MSIZE  = 1024;
   localparam int NCYC   = 3000;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   logic [NREQ-1:0]        req = '0;
   logic [NREQ*ADDR_W-1:0] addr = '0;
   logic [NREQ*4-1:0]      wr = '0;
   logic [NREQ*DATA_W-1:0] wdata = '0;

   logic [NREQ-1:0]   gnt_w      [NDUT];
   logic [NREQ-1:0]   rvalid_w   [NDUT];
   logic [DATA_W-1:0] rdata_w    [NDUT];
   logic [ADDR_W-1:0] mem_addr_w [NDUT];
   logic [3:0]        mem_wr_w   [NDUT];
   logic [DATA_W-1:0] mem_out_w  [NDUT];
   logic [DATA_W-1:0] mem_in_w   [NDUT];

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(16)) u_dut_h16 (
      .clk_i(clk), .nrst_i(nrst), .req_i(req), .addr_i(addr), .wr_i(wr), .wdata_i(wdata),
      .gnt_o(gnt_w[0]), .rvalid_o(rvalid_w[0]), .rdata_o(rdata_w[0]),
      .mem_addr_o(mem_addr_w[0]), .mem_wr_o(mem_wr_w[0]), .mem_out_o(mem_out_w[0]),
      .mem_in_i(mem_in_w[0])
   );

   dmem_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(1)) u_dut_h1 (
      .clk_i(clk), .nrst_i(nrst), .req_i(req), .addr_i(addr), .wr_i(wr), .wdata_i(wdata),
      .gnt_o(gnt_w[1]), .rvalid_o(rvalid_w[1]), .rdata_o(rdata_w[1]),
      .mem_addr_o(mem_addr_w[1]), .mem_wr_o(mem_wr_w[1]), .mem_out_o(mem_out_w[1]),
      .mem_in_i(mem_in_w[1])
   );

   function automatic logic [31:0] init_word(int i);
      return 32'hA5000000 ^ (i * 32'h00010203);
   endfunction

   // Datamem stand-ins: registered read, byte-enabled write
   logic [31:0] fmem [NDUT][MSIZE];
   logic mem_ready = 1'b0;
   always @(posedge clk) begin
      for (int k = 0; k < NDUT; k++) begin
         if (!mem_ready) begin
            for (int i = 0; i < MSIZE; i++) fmem[k][i] <= init_word(i);
         end else begin
            mem_in_w[k] <= fmem[k][mem_addr_w[k]];
            for (int b = 0; b < 4; b++)
               if (mem_wr_w[k][b]) fmem[k][mem_addr_w[k]][8*b +: 8] <= mem_out_w[k][8*b +: 8];
         end
      end
   end

   // Reference model state
   int                m_owner [NDUT];
   int                m_last  [NDUT];
   int                m_cnt   [NDUT];
   logic [NREQ-1:0]   m_rv    [NDUT];
   logic [31:0]       m_rdata [NDUT];
   logic [ADDR_W-1:0] m_addr  [NDUT];
   logic [31:0]       rmem    [NDUT][MSIZE];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [ADDR_W-1:0] addr_of(int i);
      return addr[i*ADDR_W +: ADDR_W];
   endfunction
   function automatic logic [3:0] wr_of(int i);
      return wr[i*4 +: 4];
   endfunction
   function automatic logic [31:0] wdata_of(int i);
      return wdata[i*DATA_W +: DATA_W];
   endfunction

   // First set bit of mask, searching circularly after position 'after'; -1 if none
   function automatic int rr_pick(int after, logic [NREQ-1:0] mask);
      for (int k = 1; k <= NREQ; k++) begin
         int j;
         j = (after + k) % NREQ;
         if (mask[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_reset(int k);
      m_owner[k] = -1;
      m_last[k]  = NREQ - 1;
      m_cnt[k]   = 0;
      m_rv[k]    = '0;
      m_addr[k]  = '0;
   endtask

   // Compare this cycle's outputs with the model, then advance the model one edge
   task automatic check_and_step(int k);
      int h;
      int o;
      int p;
      bit acc;
      logic [NREQ-1:0] om;
      logic [NREQ-1:0] others;
      logic [3:0]  e_wr;
      logic [ADDR_W-1:0] e_addr;
      logic [31:0] e_out;
      h  = (k == 0) ? 16 : 1;
      o  = m_owner[k];
      om = (o >= 0) ? (NREQ'(1) << o) : '0;
      others = req & ~om;
      acc = (o >= 0) && req[o];
      e_wr = 4'h0; e_addr = m_addr[k]; e_out = '0;
      if (acc) begin
         e_addr = addr_of(o);
         e_out  = wdata_of(o);
         if (nrst) e_wr = wr_of(o);
      end
      check($sformatf("d%0d.gnt", k), 64'(gnt_w[k]), 64'(om));
      check($sformatf("d%0d.rvalid", k), 64'(rvalid_w[k]), 64'(m_rv[k]));
      if (m_rv[k] != '0) check($sformatf("d%0d.rdata", k), 64'(rdata_w[k]), 64'(m_rdata[k]));
      check($sformatf("d%0d.mem_wr", k), 64'(mem_wr_w[k]), 64'(e_wr));
      check($sformatf("d%0d.mem_addr", k), 64'(mem_addr_w[k]), 64'(e_addr));
      check($sformatf("d%0d.mem_out", k), 64'(mem_out_w[k]), 64'(e_out));

      if (!nrst) begin
         model_reset(k);
         return;
      end
      m_rv[k] = '0;
      if (acc) begin
         if (wr_of(o) == 4'h0) begin
            m_rv[k]    = om;
            m_rdata[k] = rmem[k][addr_of(o)];
         end
         for (int b = 0; b < 4; b++)
            if (wr_of(o)[b]) rmem[k][addr_of(o)][8*b +: 8] = wdata_of(o)[8*b +: 8];
         m_addr[k] = addr_of(o);
      end
      if (o < 0) begin
         p = rr_pick(m_last[k], req);
         if (p >= 0) begin m_owner[k] = p; m_last[k] = p; m_cnt[k] = 0; end
      end else if (!req[o]) begin
         p = rr_pick(o, others);
         m_owner[k] = p;
         m_cnt[k]   = 0;
         if (p >= 0) m_last[k] = p;
      end else begin
         m_cnt[k]++;
         if (h != 0 && m_cnt[k] >= h && others != '0) begin
            p = rr_pick(o, others);
            m_owner[k] = p; m_last[k] = p; m_cnt[k] = 0;
         end
      end
   endtask

   initial begin
      for (int k = 0; k < NDUT; k++) begin
         for (int i = 0; i < MSIZE; i++) rmem[k][i] = init_word(i);
         model_reset(k);
      end
      nrst = 1'b0;
      req  = '1;
      @(posedge clk);
      #1 mem_ready = 1'b1;
      @(posedge clk);
      for (cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         // per-requester access fields change randomly every cycle
         for (int i = 0; i < NREQ; i++) begin
            addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 15));
            wr[i*4 +: 4]             = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            wdata[i*DATA_W +: DATA_W] = $urandom;
         end
         if (cyc < 3) begin
            nrst = 1'b0; req = 3'b111;
         end else if (cyc < 40) begin
            nrst = 1'b1; req = 3'b111;
         end else if (cyc < 45) begin
            req = 3'b000;
         end else if (cyc < 85) begin
            req = 3'b001;
         end else if (cyc < 130) begin
            req = 3'b011;
         end else if (cyc < 140) begin
            req = 3'b000;
         end else if (cyc < 160) begin
            req = 3'b001;
            wr[3:0] = 4'h0;
            nrst = !(cyc == 150 || cyc == 151);
         end else begin
            nrst = ($urandom_range(0, 149) != 0);
            for (int i = 0; i < NREQ; i++)
               if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
         end
         #2;
         for (int k = 0; k < NDUT; k++) check_and_step(k);
      end
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
